// File: rtl/cp0_timer_ctrl_pkg.sv
// Shared CP0 timer constants: controller state encoding, Compare reset value
// and prescaler sizing used by the Count sub-module.
package cp0_timer_ctrl_pkg;

   localparam logic [31:0] CP0_CMP_INIT_DEFAULT = 32'hFFFF_FFFF;
   localparam int          CP0_DIV_MAX          = 16;
   localparam int          CP0_PS_W             = 4;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } tmr_state_e;

   // Terminal prescaler value for a divide ratio of div (1..CP0_DIV_MAX).
   function automatic logic [CP0_PS_W-1:0] ps_last(input int div);
      ps_last = CP0_PS_W'(div - 1);
   endfunction

endpackage

// File: rtl/cp0_count.sv
// CP0 Count register with its clock prescaler; Count advances once every DIV
// cycles while i_tick is high, and a load restarts the prescaler phase.
module cp0_count
   import cp0_timer_ctrl_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tick,
   input  logic        i_load,
   input  logic [31:0] i_load_val,
   output logic [31:0] o_value
);

   localparam logic [CP0_PS_W-1:0] PS_LAST = ps_last(DIV);

   logic [CP0_PS_W-1:0] r_ps;
   logic [31:0]         r_value;
   logic                w_wrap;

   assign w_wrap  = i_tick && (r_ps == PS_LAST);
   assign o_value = r_value;

   // A load overrides the increment that would happen on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ps    <= '0;
         r_value <= '0;
      end else if (i_load) begin
         r_ps    <= '0;
         r_value <= i_load_val;
      end else if (i_tick) begin
         r_ps <= w_wrap ? '0 : r_ps + 1'b1;
         if (w_wrap) r_value <= r_value + 32'd1;
      end
   end

endmodule

// File: rtl/cp0_timer_ctrl.sv
// CP0 timer controller: arbitrates Compare register accesses between the
// pipeline and a hardware poll, keeps a local Compare copy and raises IP7.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | one cycle after reset: hardware writes CMP_INIT to Compare
//   ST_RUN  | normal operation: sw write > sw read > hardware poll
module cp0_timer_ctrl
   import cp0_timer_ctrl_pkg::*;
#(
   parameter logic [31:0] CMP_INIT = CP0_CMP_INIT_DEFAULT,
   parameter int          DIV      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sw_re,
   input  logic        sw_we,
   input  logic        sw_count_we,
   input  logic [31:0] sw_wdata,
   input  logic [31:0] cmp_rdata,
   output logic        cmp_r_p,
   output logic        cmp_r_h,
   output logic        cmp_we_s,
   output logic        cmp_we_h,
   output logic [31:0] cmp_wdata,
   output logic        sw_busy,
   output logic [31:0] count,
   output logic        timer_irq
);

   tmr_state_e  r_state;
   tmr_state_e  w_state_nxt;
   logic        w_count_load;
   logic        w_match;
   logic [31:0] r_cmp_cache;
   logic        r_irq;
   logic [31:0] w_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_INIT;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      cmp_r_p      = 1'b0;
      cmp_r_h      = 1'b0;
      cmp_we_s     = 1'b0;
      cmp_we_h     = 1'b0;
      cmp_wdata    = sw_wdata;
      sw_busy      = 1'b0;
      w_count_load = 1'b0;
      case (r_state)
         ST_INIT: begin
            cmp_we_h    = 1'b1;
            cmp_wdata   = CMP_INIT;
            sw_busy     = 1'b1;
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            w_count_load = sw_count_we;
            if (sw_we)      cmp_we_s = 1'b1;
            else if (sw_re) cmp_r_p  = 1'b1;
            else            cmp_r_h  = 1'b1;
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // Count free-runs from reset release, including the INIT cycle.
   cp0_count #(
      .DIV        (DIV)
   ) u_count (
      .clk        (clk),
      .rst        (rst),
      .i_tick     (1'b1),
      .i_load     (w_count_load),
      .i_load_val (sw_wdata),
      .o_value    (w_count)
   );

   assign w_match = (w_count == r_cmp_cache);

   // A Compare write clears the interrupt even when it coincides with a match.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cmp_cache <= CMP_INIT;
         r_irq       <= 1'b0;
      end else begin
         if (cmp_we_s)     r_cmp_cache <= sw_wdata;
         else if (cmp_r_h) r_cmp_cache <= cmp_rdata;

         if (cmp_we_s)     r_irq <= 1'b0;
         else if (w_match) r_irq <= 1'b1;
      end
   end

   assign count     = w_count;
   assign timer_irq = r_irq;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Bench for cp0_timer_ctrl: directed scenarios plus a randomized run checked
// against an arithmetic model of Count, Compare and the sticky interrupt.
module tb_cp0_timer_ctrl;

   localparam logic [31:0] CMP_INIT = 32'hFFFF_FFFF;
   localparam int          DIV      = 2;

   logic        clk;
   logic        rst;
   logic        sw_re;
   logic        sw_we;
   logic        sw_count_we;
   logic [31:0] sw_wdata;
   logic [31:0] cmp_rdata;
   logic        cmp_r_p;
   logic        cmp_r_h;
   logic        cmp_we_s;
   logic        cmp_we_h;
   logic [31:0] cmp_wdata;
   logic        sw_busy;
   logic [31:0] count;
   logic        timer_irq;

   int n_vec = 0;
   int n_err = 0;

   cp0_timer_ctrl #(
      .CMP_INIT    (CMP_INIT),
      .DIV         (DIV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw_re       (sw_re),
      .sw_we       (sw_we),
      .sw_count_we (sw_count_we),
      .sw_wdata    (sw_wdata),
      .cmp_rdata   (cmp_rdata),
      .cmp_r_p     (cmp_r_p),
      .cmp_r_h     (cmp_r_h),
      .cmp_we_s    (cmp_we_s),
      .cmp_we_h    (cmp_we_h),
      .cmp_wdata   (cmp_wdata),
      .sw_busy     (sw_busy),
      .count       (count),
      .timer_irq   (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare register unit: written by either write strobe, read combinationally.
   logic [31:0] cmp_mem = 32'h0;
   always @(posedge clk) begin
      if (cmp_we_h || cmp_we_s) cmp_mem <= cmp_wdata;
   end
   assign cmp_rdata = cmp_mem;

   // Reference model: Count = last loaded value + elapsed cycles / DIV.
   logic        m_init;
   logic [31:0] m_base;
   logic [31:0] m_cyc;
   logic [31:0] m_cmp;
   logic        m_irq;
   logic [31:0] m_count;
   assign m_count = m_base + m_cyc / 32'(DIV);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_init <= 1'b1;
         m_base <= 32'h0;
         m_cyc  <= 32'h0;
         m_cmp  <= CMP_INIT;
         m_irq  <= 1'b0;
      end else begin
         m_init <= 1'b0;
         if (!m_init && sw_we) begin
            m_irq <= 1'b0;
            m_cmp <= sw_wdata;
         end else if (m_count == m_cmp) begin
            m_irq <= 1'b1;
         end
         if (!m_init && sw_count_we) begin
            m_base <= sw_wdata;
            m_cyc  <= 32'h0;
         end else begin
            m_cyc <= m_cyc + 32'd1;
         end
      end
   end

   task automatic idle();
      sw_re       = 1'b0;
      sw_we       = 1'b0;
      sw_count_we = 1'b0;
      sw_wdata    = 32'h0;
   endtask

   // Leaves the bench 1 ns into the first cycle after reset release.
   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      n_vec++;
      if (count !== 32'h0) begin
         n_err++; $display("FAIL reset_count got=%h exp=%h", count, 32'h0);
      end
      n_vec++;
      if (timer_irq !== 1'b0) begin
         n_err++; $display("FAIL reset_irq got=%b exp=0", timer_irq);
      end
      @(negedge clk);
      rst         = 1'b1;
      sw_we       = 1'b1;
      sw_re       = 1'b1;
      sw_count_we = 1'b1;
      sw_wdata    = 32'h0000_1234;
      #1;
      n_vec++;
      if ({cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h} !== 4'b0001) begin
         n_err++; $display("FAIL init_strobes got=%b exp=0001", {cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h});
      end
      n_vec++;
      if (cmp_wdata !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL init_wdata got=%h exp=ffffffff", cmp_wdata);
      end
      n_vec++;
      if (sw_busy !== 1'b1) begin
         n_err++; $display("FAIL init_busy got=%b exp=1", sw_busy);
      end
      @(negedge clk);
      idle();
      #1;
      n_vec++;
      if ({cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h} !== 4'b0100) begin
         n_err++; $display("FAIL run_strobes got=%b exp=0100", {cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h});
      end
      n_vec++;
      if (sw_busy !== 1'b0) begin
         n_err++; $display("FAIL run_busy got=%b exp=0", sw_busy);
      end
      n_vec++;
      if (count !== 32'h0) begin
         n_err++; $display("FAIL init_ignores_count_we got=%h exp=%h", count, 32'h0);
      end
   endtask

   task automatic test_count_seq();
      logic [31:0] exp_seq [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         n_vec++;
         if (count !== exp_seq[i]) begin
            n_err++; $display("FAIL count_seq[%0d] got=%h exp=%h", i, count, exp_seq[i]);
         end
         n_vec++;
         if (timer_irq !== 1'b0) begin
            n_err++; $display("FAIL count_seq_irq[%0d] got=%b exp=0", i, timer_irq);
         end
      end
   endtask

   task automatic test_cmp_match();
      logic [31:0] prev;
      bit          seen;
      do_reset();
      @(negedge clk);
      sw_we    = 1'b1;
      sw_wdata = 32'd5;
      #1;
      n_vec++;
      if (cmp_we_s !== 1'b1 || cmp_wdata !== 32'd5) begin
         n_err++; $display("FAIL cmp_write we_s=%b wdata=%h exp we_s=1 wdata=5", cmp_we_s, cmp_wdata);
      end
      prev = count;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         idle();
         #1;
         if (timer_irq === 1'b1) seen = 1'b1;
         else prev = count;
      end
      n_vec++;
      if (!seen) begin
         n_err++; $display("FAIL cmp_match_timeout irq=%b exp=1 within 40 cycles", timer_irq);
      end
      n_vec++;
      if (prev !== 32'd5) begin
         n_err++; $display("FAIL cmp_match_count got=%h exp=%h", prev, 32'd5);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_vec++;
         if (timer_irq !== 1'b1) begin
            n_err++; $display("FAIL irq_sticky[%0d] got=%b exp=1", i, timer_irq);
         end
      end
   endtask

   task automatic test_clear();
      @(negedge clk);
      sw_we    = 1'b1;
      sw_re    = 1'b1;
      sw_wdata = 32'h100;
      #1;
      n_vec++;
      if ({cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h} !== 4'b0010) begin
         n_err++; $display("FAIL we_re_priority got=%b exp=0010", {cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h});
      end
      @(negedge clk);
      idle();
      #1;
      n_vec++;
      if (timer_irq !== 1'b0) begin
         n_err++; $display("FAIL irq_clear got=%b exp=0", timer_irq);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_cnt [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1};
      logic        exp_irq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      @(negedge clk);
      sw_we    = 1'b1;
      sw_wdata = 32'h0;
      @(negedge clk);
      idle();
      sw_count_we = 1'b1;
      sw_wdata    = 32'hFFFF_FFFE;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         idle();
         #1;
         n_vec++;
         if (count !== exp_cnt[i]) begin
            n_err++; $display("FAIL wrap_count[%0d] got=%h exp=%h", i, count, exp_cnt[i]);
         end
         n_vec++;
         if (timer_irq !== exp_irq[i]) begin
            n_err++; $display("FAIL wrap_irq[%0d] got=%b exp=%b", i, timer_irq, exp_irq[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      sw_we    = 1'b1;
      sw_wdata = 32'h40;
      @(negedge clk);
      idle();
      sw_count_we = 1'b1;
      sw_wdata    = 32'h40;
      @(negedge clk);
      idle();
      @(negedge clk);
      #1;
      n_vec++;
      if (count !== 32'h40 || timer_irq !== 1'b1) begin
         n_err++; $display("FAIL mid_precond count=%h irq=%b exp count=40 irq=1", count, timer_irq);
      end
      #1;
      rst = 1'b0;
      #1;
      n_vec++;
      if (count !== 32'h0 || timer_irq !== 1'b0) begin
         n_err++; $display("FAIL mid_async_reset count=%h irq=%b exp count=0 irq=0", count, timer_irq);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if ({cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h} !== 4'b0001 || cmp_wdata !== CMP_INIT || sw_busy !== 1'b1) begin
         n_err++; $display("FAIL mid_init strobes=%b wdata=%h busy=%b exp 0001 ffffffff 1",
                           {cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h}, cmp_wdata, sw_busy);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h} !== 4'b0100 || sw_busy !== 1'b0 || count !== 32'h0) begin
         n_err++; $display("FAIL mid_run strobes=%b busy=%b count=%h exp 0100 0 0",
                           {cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h}, sw_busy, count);
      end
   endtask

   task automatic test_random();
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic        e_busy;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         sw_we       = ($urandom_range(0, 7) == 0);
         sw_re       = ($urandom_range(0, 3) == 0);
         sw_count_we = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       sw_wdata = $urandom;
            1:       sw_wdata = m_count + 32'($urandom_range(0, 5));
            2:       sw_wdata = m_count;
            default: sw_wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         endcase
         #1;
         if (m_init) begin
            e_strb  = 4'b0001;
            e_wdata = CMP_INIT;
            e_busy  = 1'b1;
         end else begin
            e_strb  = sw_we ? 4'b0010 : (sw_re ? 4'b1000 : 4'b0100);
            e_wdata = sw_wdata;
            e_busy  = 1'b0;
         end
         n_vec++;
         if ({cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h} !== e_strb) begin
            n_err++; $display("FAIL rnd_strobes cyc=%0d got=%b exp=%b", i, {cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h}, e_strb);
         end
         n_vec++;
         if (cmp_wdata !== e_wdata) begin
            n_err++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", i, cmp_wdata, e_wdata);
         end
         n_vec++;
         if (sw_busy !== e_busy) begin
            n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, sw_busy, e_busy);
         end
         n_vec++;
         if (count !== m_count) begin
            n_err++; $display("FAIL rnd_count cyc=%0d got=%h exp=%h", i, count, m_count);
         end
         n_vec++;
         if (timer_irq !== m_irq) begin
            n_err++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, timer_irq, m_irq);
         end
      end
      idle();
   endtask

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_count_seq();
      test_cmp_match();
      test_clear();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cp0_timer_ctrl.md
CP0_TIMER_CTRL -- requirements
Module: cp0_timer_ctrl

Interface
REQ-001 Parameter CMP_INIT, default 32'hFFFF_FFFF, meaning the Compare value written by hardware after reset.
REQ-002 Parameter DIV, default 2, meaning the number of clk cycles per Count increment (1..16).
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 sw_re  input  1  pipeline (mfc0) read of Compare this cycle.
REQ-006 sw_we  input  1  pipeline (mtc0) write of Compare this cycle.
REQ-007 sw_count_we  input  1  pipeline (mtc0) write of Count this cycle.
REQ-008 sw_wdata  input  32  pipeline write data for Compare or Count.
REQ-009 cmp_rdata  input  32  read data returned by the Compare register unit.
REQ-010 cmp_r_p, cmp_r_h, cmp_we_s, cmp_we_h  output  1 each  read/write strobes to the Compare register unit (pipeline read, hardware read, software write, hardware write).
REQ-011 cmp_wdata  output  32  write data to the Compare register unit.
REQ-012 sw_busy  output  1  pipeline must hold Compare/Count accesses this cycle.
REQ-013 count  output  32  current Count value.
REQ-014 timer_irq  output  1  sticky timer interrupt (IP7).

Function
REQ-015 The block SHALL implement a two-state FSM: INIT, RUN; INIT lasts exactly one cycle after reset release, then RUN forever.
REQ-016 In INIT the block SHALL assert cmp_we_h=1, cmp_wdata=CMP_INIT, sw_busy=1, all other strobes 0; pipeline requests in INIT are ignored.
REQ-017 In RUN, at most one of cmp_r_p, cmp_r_h, cmp_we_s SHALL be 1 per cycle, priority sw_we > sw_re > hardware poll; cmp_we_h SHALL be 0.
REQ-018 sw_we in RUN SHALL drive cmp_we_s=1, cmp_wdata=sw_wdata, load cmp_cache<=sw_wdata and clear timer_irq at the same edge.
REQ-019 sw_re (without sw_we) in RUN SHALL drive cmp_r_p=1, zero added latency (data returned combinationally via cmp_rdata).
REQ-020 Otherwise in RUN the block SHALL drive cmp_r_h=1 and load cmp_cache<=cmp_rdata.
REQ-021 A prescaler SHALL count 0..DIV-1; count SHALL increment by 1 (mod 2^32, FFFF_FFFF wraps to 0) at the edge where the prescaler equals DIV-1.
REQ-022 sw_count_we SHALL load count<=sw_wdata and prescaler<=0, overriding a same-cycle increment; it is legal in the same cycle as sw_we (both use sw_wdata).
REQ-023 timer_irq SHALL be set at any edge where count==cmp_cache and sw_we=0, and stay set until a Compare write; Count writes do not clear it.
REQ-024 sw_we and a match in the same cycle SHALL leave timer_irq cleared (clear wins).
REQ-025 cmp_wdata SHALL be sw_wdata whenever not in INIT.

Reset
REQ-026 rst low SHALL asynchronously force state=INIT, count=0, prescaler=0, cmp_cache=CMP_INIT, timer_irq=0.
REQ-027 Reset asserted mid-operation SHALL abort any access; strobes follow the INIT rule once rst returns high.

Structure
REQ-028 FSM state encoding and CMP_INIT default SHALL live in the shared CP0 header alongside existing CP0 constants.
REQ-029 The prescaler+Count pair SHALL be one sub-module, cp0_count, with load, tick and value ports; registers use the existing enabled-flop component.

Verification
REQ-030 Reset release -> cycle 1: cmp_we_h=1, cmp_wdata=FFFF_FFFF, sw_busy=1; cycle 2: cmp_r_h=1, sw_busy=0.
REQ-031 DIV=2, no writes -> count reads 0,0,1,1,2 on successive cycles after reset; timer_irq stays 0.
REQ-032 Write Compare=5 (cmp_we_s=1 that cycle) -> timer_irq rises at the edge where count==5, stays high.
REQ-033 timer_irq high, write Compare=0x100 -> timer_irq low next cycle; same-cycle sw_re with sw_we -> only cmp_we_s asserted.
REQ-034 Write Count=FFFF_FFFE, Compare=0 -> count wraps FFFF_FFFF->0, timer_irq set at the 0 match.
REQ-035 Assert rst for one cycle while count=0x40 and timer_irq=1 -> count=0, timer_irq=0 immediately; INIT sequence repeats.
